// File: rtl/cov_matrix_loader.sv
// Assembles a symmetric SIZE_N x SIZE_N double matrix from a serial upper-triangle
// stream, then holds it with a level start until the consumer reports done.
module cov_matrix_loader #(
  parameter int unsigned SIZE_N = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [63:0]                          in_data,
  input  logic                                 in_valid,
  input  logic                                 in_last,
  output logic                                 in_ready,
  input  logic                                 consumer_done,
  output logic [SIZE_N-1:0][SIZE_N-1:0][63:0]  timed_matrix,
  output logic                                 start,
  output logic                                 busy,
  output logic                                 err_len,
  output logic                                 err_diag
);

  localparam int unsigned TOTAL = SIZE_N * (SIZE_N + 1) / 2;
  localparam int unsigned CW    = $clog2(TOTAL + 1);
  localparam int unsigned RW    = (SIZE_N > 1) ? $clog2(SIZE_N) : 1;

  typedef enum logic {LOAD = 1'b0, HOLD = 1'b1} state_t;

  state_t          state;
  state_t          next_state;
  logic [RW-1:0]   row;
  logic [RW-1:0]   col;
  logic [CW-1:0]   count;
  logic            xfer;
  logic            frame_end;
  logic            neg_diag;
  logic [63:0]     wdata;

  assign xfer      = in_valid && in_ready;
  assign frame_end = (count == CW'(TOTAL - 1));
  // -0.0 has an all-zero magnitude and passes through untouched
  assign neg_diag  = (row == col) && in_data[63] && (|in_data[62:0]);
  assign wdata     = neg_diag ? 64'h0 : in_data;

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      LOAD: if (xfer && frame_end) next_state = HOLD;
      HOLD: if (consumer_done)     next_state = LOAD;
      default: next_state = LOAD;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    start    = 1'b0;
    case (state)
      LOAD: in_ready = 1'b1;
      HOLD: start    = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Triangle walk: wrapping off the last column lands on the next row's diagonal
  always_ff @(posedge clk) begin
    if (rst) begin
      row   <= '0;
      col   <= '0;
      count <= '0;
      busy  <= 1'b0;
    end else if (xfer) begin
      if (frame_end || in_last) begin
        row   <= '0;
        col   <= '0;
        count <= '0;
        busy  <= 1'b0;
      end else begin
        count <= count + CW'(1);
        busy  <= 1'b1;
        if (col == RW'(SIZE_N - 1)) begin
          row <= row + RW'(1);
          col <= row + RW'(1);
        end else begin
          col <= col + RW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_len  <= 1'b0;
      err_diag <= 1'b0;
    end else if (xfer) begin
      if (frame_end ? !in_last : in_last) err_len <= 1'b1;
      if (neg_diag)                        err_diag <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timed_matrix <= '0;
    end else if (xfer) begin
      timed_matrix[row][col] <= wdata;
      timed_matrix[col][row] <= wdata;
    end
  end

endmodule

// File: tb/tb_cov_matrix_loader.sv
// Scoreboard bench for cov_matrix_loader at SIZE_N=4: stimulus pushes expected
// held matrices, a negedge monitor checks them when start rises.
module tb_cov_matrix_loader;

  localparam int unsigned N   = 4;
  localparam int          TOT = 10;

  typedef logic [N-1:0][N-1:0][63:0] mat_t;
  typedef struct {
    mat_t m;
    int   rise;
    logic el;
    logic ed;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        consumer_done;
  mat_t        timed_matrix;
  logic        start;
  logic        busy;
  logic        err_len;
  logic        err_diag;

  cov_matrix_loader #(.SIZE_N(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .consumer_done (consumer_done),
    .timed_matrix  (timed_matrix),
    .start         (start),
    .busy          (busy),
    .err_len       (err_len),
    .err_diag      (err_diag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  mat_t        mdl;
  logic        m_el;
  logic        m_ed;
  logic        start_q = 1'b0;
  logic [63:0] vals [TOT];
  int          pr [TOT] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
  int          pc [TOT] = '{0, 1, 2, 3, 1, 2, 3, 2, 3, 3};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (start === 1'b1 && start_q !== 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_start", 64'd0, 64'd1);
      end else begin
        mon_e = sb.pop_front();
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++)
            chk($sformatf("cell[%0d][%0d]", r, c), timed_matrix[r][c], mon_e.m[r][c]);
        chk("start_cycle", 64'(cyc), 64'(mon_e.rise));
        chk("hold_err_len", 64'(err_len), 64'(mon_e.el));
        chk("hold_err_diag", 64'(err_diag), 64'(mon_e.ed));
      end
    end
    start_q <= start;
  end

  task automatic set_vals();
    for (int i = 0; i < TOT; i++) vals[i] = $realtobits(real'(i + 1));
  endtask

  task automatic send_range(input int lo, input int hi, input int last_at, input bit gaps);
    for (int i = lo; i <= hi; i++) begin
      logic [63:0] v;
      int          n;
      exp_t        e;
      if (gaps) begin
        int g = $urandom_range(0, 2);
        repeat (g) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      in_data  = vals[i];
      in_last  = (i == last_at);
      in_valid = 1'b1;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (in_ready !== 1'b1) chk("ready_timeout", 64'(in_ready), 64'd1);
      v = vals[i];
      if (pr[i] == pc[i] && v[63] && (|v[62:0])) begin
        v = 64'h0;
        m_ed = 1'b1;
      end
      mdl[pr[i]][pc[i]] = v;
      mdl[pc[i]][pr[i]] = v;
      if ((i == last_at) != (i == TOT - 1)) m_el = 1'b1;
      if (i == TOT - 1) begin
        e.m = mdl; e.rise = cyc + 1; e.el = m_el; e.ed = m_ed;
        sb.push_back(e);
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (start !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", 64'(start), 64'd1);
  endtask

  // Called on the first HOLD negedge; drops consumer_done on the k-th HOLD cycle
  task automatic release_hold(input int k);
    repeat (k - 1) @(negedge clk);
    consumer_done = 1'b1;
    @(negedge clk);
    consumer_done = 1'b0;
    chk("rel_start", 64'(start), 64'd0);
    chk("rel_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic check_reset_state();
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_start", 64'(start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err_len", 64'(err_len), 64'd0);
    chk("rst_err_diag", 64'(err_diag), 64'd0);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        chk($sformatf("rst_cell[%0d][%0d]", r, c), timed_matrix[r][c], 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; consumer_done = 1'b0;
    mdl = '0; m_el = 1'b0; m_ed = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_state();

    // basic frame, back-to-back
    set_vals();
    send_range(0, 9, 9, 1'b0);
    wait_start();
    chk("m03", timed_matrix[0][3], $realtobits(4.0));
    chk("m30", timed_matrix[3][0], $realtobits(4.0));
    chk("m33", timed_matrix[3][3], $realtobits(10.0));
    chk("hold_busy", 64'(busy), 64'd0);
    // in_valid during HOLD must not be accepted or disturb the matrix
    in_data = 64'hDEAD_BEEF_0000_0001; in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("hold_ready", 64'(in_ready), 64'd0);
      chk("hold_m00", timed_matrix[0][0], $realtobits(1.0));
    end
    in_valid = 1'b0;
    release_hold(1);

    // same stream with random gaps, released on the first HOLD cycle
    send_range(0, 9, 9, 1'b1);
    wait_start();
    release_hold(1);

    // consumer_done pulsed mid-LOAD is ignored
    send_range(0, 2, -1, 1'b0);
    consumer_done = 1'b1;
    @(negedge clk);
    consumer_done = 1'b0;
    chk("midload_ready", 64'(in_ready), 64'd1);
    chk("midload_start", 64'(start), 64'd0);
    chk("midload_busy", 64'(busy), 64'd1);
    send_range(3, 9, 9, 1'b0);
    wait_start();
    release_hold(2);

    // early in_last on the 6th entry
    send_range(0, 5, 5, 1'b0);
    repeat (2) @(negedge clk);
    chk("early_err_len", 64'(err_len), 64'd1);
    chk("early_start", 64'(start), 64'd0);
    chk("early_ready", 64'(in_ready), 64'd1);
    chk("early_busy", 64'(busy), 64'd0);
    send_range(0, 9, 9, 1'b0);
    wait_start();
    chk("after_early_err_len", 64'(err_len), 64'd1);
    release_hold(1);

    // -0.0 on the (2,2) diagonal passes without a flag
    vals[7] = 64'h8000_0000_0000_0000;
    send_range(0, 9, 9, 1'b0);
    wait_start();
    chk("negzero_m22", timed_matrix[2][2], 64'h8000_0000_0000_0000);
    chk("negzero_err_diag", 64'(err_diag), 64'd0);
    release_hold(1);

    // negative (1,1) diagonal is clamped and flagged
    vals[4] = 64'hC004_0000_0000_0000;
    send_range(0, 9, 9, 1'b0);
    wait_start();
    chk("neg_m11", timed_matrix[1][1], 64'h0);
    chk("neg_m22", timed_matrix[2][2], 64'h8000_0000_0000_0000);
    chk("neg_err_diag", 64'(err_diag), 64'd1);
    release_hold(1);

    // reset after 5 entries, then a clean frame from (0,0)
    set_vals();
    send_range(0, 4, -1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl = '0; m_el = 1'b0; m_ed = 1'b0;
    check_reset_state();
    send_range(0, 9, 9, 1'b0);
    wait_start();
    release_hold(1);

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
